// File: rtl/dsp_host_arbiter.sv
// Round-robin arbiter sharing the DSP command channel between the Wishbone and
// SPI hosts; tracks the DSP ack handshake and bounds each transaction by a timeout.
module dsp_host_arbiter #(
   parameter int BUS_WIDTH     = 32,
   parameter int OUTPUT_WIDTH  = 32,
   parameter int TIMEOUT       = 255,
   parameter int TIMEOUT_WIDTH = 8
) (
   input  logic                    i_CLK,
   input  logic                    i_RST_N,
   input  logic                    i_WISH_REQ,
   input  logic [BUS_WIDTH-1:0]    i_WISH_DATA,
   input  logic                    i_SPI_REQ,
   input  logic [BUS_WIDTH-1:0]    i_SPI_DATA,
   output logic                    o_WISH_DONE,
   output logic                    o_WISH_ERR,
   output logic [OUTPUT_WIDTH-1:0] o_WISH_RESULT,
   output logic                    o_SPI_DONE,
   output logic                    o_SPI_ERR,
   output logic [OUTPUT_WIDTH-1:0] o_SPI_RESULT,
   output logic                    o_DSP_WISH_VALID,
   output logic [BUS_WIDTH-1:0]    o_DSP_WISH_DATA,
   output logic                    o_DSP_SPI_VALID,
   output logic [BUS_WIDTH-1:0]    o_DSP_SPI_DATA,
   input  logic                    i_DSP_WEIGHT_ACK,
   input  logic                    i_DSP_DATA_ACK,
   input  logic                    i_DSP_CONV_ACK,
   input  logic [OUTPUT_WIDTH-1:0] i_DSP_RESULT,
   output logic                    o_BUSY,
   output logic                    o_OWNER,
   output logic [1:0]              o_PHASE
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_LOW,
      S_WAIT_HIGH,
      S_DONE
   } state_t;

   localparam logic [1:0] PH_WEIGHT = 2'd0;
   localparam logic [1:0] PH_DATA   = 2'd1;
   localparam logic [1:0] PH_CONV   = 2'd2;
   localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

   state_t                    r_state;
   logic                      r_last_spi;
   logic                      r_owner;
   logic                      r_busy;
   logic [1:0]                r_phase;
   logic [TIMEOUT_WIDTH-1:0]  r_cnt;
   logic                      r_wish_valid;
   logic                      r_spi_valid;
   logic [BUS_WIDTH-1:0]      r_wish_lane;
   logic [BUS_WIDTH-1:0]      r_spi_lane;
   logic                      r_wish_done;
   logic                      r_spi_done;
   logic                      r_wish_err;
   logic                      r_spi_err;
   logic [OUTPUT_WIDTH-1:0]   r_wish_result;
   logic [OUTPUT_WIDTH-1:0]   r_spi_result;

   logic                      w_ready;
   logic                      w_any_req;
   logic                      w_grant_spi;
   logic [1:0]                w_phase_sel;
   logic                      w_cap_ack;
   logic                      w_fin_ok;
   logic                      w_fin_err;
   logic [OUTPUT_WIDTH-1:0]   w_fin_result;

   assign w_ready   = i_DSP_WEIGHT_ACK | i_DSP_DATA_ACK | i_DSP_CONV_ACK;
   assign w_any_req = i_WISH_REQ | i_SPI_REQ;

   // On a tie the host that was not served last wins.
   assign w_grant_spi = i_SPI_REQ & (~i_WISH_REQ | ~r_last_spi);

   always_comb begin
      w_phase_sel = PH_WEIGHT;
      if (i_DSP_CONV_ACK)
         w_phase_sel = PH_CONV;
      else if (i_DSP_DATA_ACK)
         w_phase_sel = PH_DATA;
   end

   always_comb begin
      case (r_phase)
         PH_CONV: w_cap_ack = i_DSP_CONV_ACK;
         PH_DATA: w_cap_ack = i_DSP_DATA_ACK;
         default: w_cap_ack = i_DSP_WEIGHT_ACK;
      endcase
   end

   // A ready seen in WAIT_HIGH completes normally even on the final counted cycle.
   always_comb begin
      w_fin_ok  = 1'b0;
      w_fin_err = 1'b0;
      if (r_state == S_WAIT_HIGH && w_ready)
         w_fin_ok = 1'b1;
      else if ((r_state == S_WAIT_LOW || r_state == S_WAIT_HIGH) && r_cnt == CNT_LAST)
         w_fin_err = 1'b1;
   end

   assign w_fin_result = (w_fin_ok && r_phase == PH_CONV) ? i_DSP_RESULT : '0;

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         r_state       <= S_IDLE;
         r_last_spi    <= 1'b1;
         r_owner       <= 1'b0;
         r_busy        <= 1'b0;
         r_phase       <= PH_WEIGHT;
         r_cnt         <= '0;
         r_wish_valid  <= 1'b0;
         r_spi_valid   <= 1'b0;
         r_wish_lane   <= '0;
         r_spi_lane    <= '0;
         r_wish_done   <= 1'b0;
         r_spi_done    <= 1'b0;
         r_wish_err    <= 1'b0;
         r_spi_err     <= 1'b0;
         r_wish_result <= '0;
         r_spi_result  <= '0;
      end else begin
         r_wish_valid <= 1'b0;
         r_spi_valid  <= 1'b0;
         r_wish_done  <= 1'b0;
         r_spi_done   <= 1'b0;
         r_wish_err   <= 1'b0;
         r_spi_err    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_ready && w_any_req) begin
                  r_owner <= w_grant_spi;
                  r_phase <= w_phase_sel;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  if (w_grant_spi) begin
                     r_spi_valid <= 1'b1;
                     r_spi_lane  <= i_SPI_DATA;
                  end else begin
                     r_wish_valid <= 1'b1;
                     r_wish_lane  <= i_WISH_DATA;
                  end
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT_LOW;
            end
            S_WAIT_LOW, S_WAIT_HIGH: begin
               if (w_fin_ok || w_fin_err) begin
                  r_state <= S_DONE;
                  if (r_owner) begin
                     r_spi_done   <= 1'b1;
                     r_spi_err    <= w_fin_err;
                     r_spi_result <= w_fin_result;
                  end else begin
                     r_wish_done   <= 1'b1;
                     r_wish_err    <= w_fin_err;
                     r_wish_result <= w_fin_result;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_state == S_WAIT_LOW && !w_cap_ack)
                     r_state <= S_WAIT_HIGH;
               end
            end
            S_DONE: begin
               r_last_spi  <= r_owner;
               r_busy      <= 1'b0;
               r_wish_lane <= '0;
               r_spi_lane  <= '0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_DSP_WISH_VALID = r_wish_valid;
   assign o_DSP_SPI_VALID  = r_spi_valid;
   assign o_DSP_WISH_DATA  = r_wish_lane;
   assign o_DSP_SPI_DATA   = r_spi_lane;
   assign o_WISH_DONE      = r_wish_done;
   assign o_SPI_DONE       = r_spi_done;
   assign o_WISH_ERR       = r_wish_err;
   assign o_SPI_ERR        = r_spi_err;
   assign o_WISH_RESULT    = r_wish_result;
   assign o_SPI_RESULT     = r_spi_result;
   assign o_BUSY           = r_busy;
   assign o_OWNER          = r_owner;
   assign o_PHASE          = r_phase;

   a_one_valid: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
      !(r_wish_valid && r_spi_valid));
   a_one_done: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
      !(r_wish_done && r_spi_done));

endmodule

// File: tb/tb_dsp_host_arbiter.sv
// Directed bench for dsp_host_arbiter: inputs driven and outputs sampled on the
// falling edge; the DSP ack handshake is scripted cycle by cycle in each task.
module tb_dsp_host_arbiter;
   localparam int BW = 32;
   localparam int OW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wreq = 1'b0, sreq = 1'b0;
   logic [BW-1:0] wdata = '0, sdata = '0;
   logic          wack = 1'b0, dack = 1'b0, cack = 1'b0;
   logic [OW-1:0] dres = '0;
   logic          wdone, sdone, werr, serr, wvld, svld, busy, owner;
   logic [OW-1:0] wres, sres;
   logic [BW-1:0] wdo, sdo;
   logic [1:0]    phase;

   int checks = 0;
   int errors = 0;

   dsp_host_arbiter #(
      .BUS_WIDTH(BW), .OUTPUT_WIDTH(OW), .TIMEOUT(8), .TIMEOUT_WIDTH(8)
   ) dut (
      .i_CLK(clk), .i_RST_N(rst_n),
      .i_WISH_REQ(wreq), .i_WISH_DATA(wdata),
      .i_SPI_REQ(sreq), .i_SPI_DATA(sdata),
      .o_WISH_DONE(wdone), .o_WISH_ERR(werr), .o_WISH_RESULT(wres),
      .o_SPI_DONE(sdone), .o_SPI_ERR(serr), .o_SPI_RESULT(sres),
      .o_DSP_WISH_VALID(wvld), .o_DSP_WISH_DATA(wdo),
      .o_DSP_SPI_VALID(svld), .o_DSP_SPI_DATA(sdo),
      .i_DSP_WEIGHT_ACK(wack), .i_DSP_DATA_ACK(dack), .i_DSP_CONV_ACK(cack),
      .i_DSP_RESULT(dres),
      .o_BUSY(busy), .o_OWNER(owner), .o_PHASE(phase)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++; if ({wvld, svld, wdone, sdone, werr, serr, busy, owner, phase} !== 10'd0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {wvld, svld, wdone, sdone, werr, serr, busy, owner, phase}); end
      checks++; if ({wdo, sdo} !== 64'd0) begin errors++; $display("FAIL reset_lane_data: got %h want 0", {wdo, sdo}); end
      checks++; if ({wres, sres} !== 64'd0) begin errors++; $display("FAIL reset_results: got %h want 0", {wres, sres}); end
      tick();
      rst_n = 1'b1;
   endtask

   // Both hosts request from reset: Wishbone first, then SPI with minimum gap.
   task automatic test_tie();
      wdata = 32'h1111_1111; sdata = 32'h2222_2222;
      wreq = 1'b1; sreq = 1'b1; wack = 1'b1;
      tick();
      checks++; if ({wvld, svld} !== 2'b10) begin errors++; $display("FAIL tie_first_grant: got %b want 10", {wvld, svld}); end
      checks++; if (wdo !== 32'h1111_1111) begin errors++; $display("FAIL tie_wish_lane: got %h want 11111111", wdo); end
      checks++; if (sdo !== 32'h0) begin errors++; $display("FAIL tie_spi_lane_idle: got %h want 0", sdo); end
      checks++; if ({busy, owner} !== 2'b10) begin errors++; $display("FAIL tie_busy_owner: got %b want 10", {busy, owner}); end
      tick();
      checks++; if (wvld !== 1'b0) begin errors++; $display("FAIL tie_valid_one_cycle: got %b want 0", wvld); end
      wack = 1'b0;
      tick();
      wack = 1'b1;
      tick();
      checks++; if ({wdone, sdone} !== 2'b10) begin errors++; $display("FAIL tie_wish_done: got %b want 10", {wdone, sdone}); end
      checks++; if (sdo !== 32'h0) begin errors++; $display("FAIL tie_spi_lane_during_wish: got %h want 0", sdo); end
      wreq = 1'b0;
      tick();
      checks++; if ({busy, svld} !== 2'b00) begin errors++; $display("FAIL tie_idle_gap: got %b want 00", {busy, svld}); end
      tick();
      checks++; if ({wvld, svld, owner} !== 3'b011) begin errors++; $display("FAIL tie_second_grant: got %b want 011", {wvld, svld, owner}); end
      checks++; if ({wdo, sdo} !== {32'h0, 32'h2222_2222}) begin errors++; $display("FAIL tie_spi_lane: got %h want 0000000022222222", {wdo, sdo}); end
      tick();
      wack = 1'b0;
      tick();
      wack = 1'b1;
      tick();
      checks++; if ({sdone, serr, wdone} !== 3'b100) begin errors++; $display("FAIL tie_spi_done: got %b want 100", {sdone, serr, wdone}); end
      sreq = 1'b0;
      tick();
   endtask

   task automatic test_weight();
      wdata = 32'h0000_00A5; wreq = 1'b1; wack = 1'b1;
      tick();
      checks++; if ({wvld, wdo, phase} !== {1'b1, 32'h0000_00A5, 2'd0}) begin errors++; $display("FAIL weight_issue: got %b/%h/%0d want 1/000000a5/0", wvld, wdo, phase); end
      tick();
      checks++; if (wvld !== 1'b0) begin errors++; $display("FAIL weight_valid_drop: got %b want 0", wvld); end
      wack = 1'b0;
      tick();
      checks++; if (wdone !== 1'b0) begin errors++; $display("FAIL weight_early_done: got %b want 0", wdone); end
      wack = 1'b1;
      tick();
      checks++; if ({wdone, werr, wres, phase} !== {1'b1, 1'b0, 32'h0, 2'd0}) begin errors++; $display("FAIL weight_done: got %b/%b/%h/%0d want 1/0/0/0", wdone, werr, wres, phase); end
      wreq = 1'b0;
      tick();
      checks++; if (wdone !== 1'b0) begin errors++; $display("FAIL weight_done_pulse: got %b want 0", wdone); end
   endtask

   task automatic test_conv();
      sdata = 32'h0000_C0C0; sreq = 1'b1; wack = 1'b0; cack = 1'b1;
      tick();
      checks++; if ({svld, phase} !== {1'b1, 2'd2}) begin errors++; $display("FAIL conv_issue: got %b/%0d want 1/2", svld, phase); end
      tick();
      cack = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL conv_early_done: got %b want 0", sdone); end
      dres = 32'h0000_1234; cack = 1'b1;
      tick();
      checks++; if ({sdone, serr, sres, phase} !== {1'b1, 1'b0, 32'h0000_1234, 2'd2}) begin errors++; $display("FAIL conv_done: got %b/%b/%h/%0d want 1/0/00001234/2", sdone, serr, sres, phase); end
      sreq = 1'b0;
      tick();
      checks++; if ({sdone, sres} !== {1'b0, 32'h0000_1234}) begin errors++; $display("FAIL conv_result_hold: got %b/%h want 0/00001234", sdone, sres); end
   endtask

   task automatic test_not_ready();
      cack = 1'b0; wack = 1'b0; dack = 1'b0;
      wdata = 32'h0000_BEEF; wreq = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++; if ({wvld, busy} !== 2'b00) begin errors++; $display("FAIL notready_hold_off: got %b want 00", {wvld, busy}); end
      wack = 1'b1;
      tick();
      checks++; if ({wvld, wdo} !== {1'b1, 32'h0000_BEEF}) begin errors++; $display("FAIL notready_grant: got %b/%h want 1/0000beef", wvld, wdo); end
      tick();
      wack = 1'b0;
      tick();
      wack = 1'b1;
      tick();
      checks++; if (wdone !== 1'b1) begin errors++; $display("FAIL notready_done: got %b want 1", wdone); end
      wreq = 1'b0;
      tick();
   endtask

   // Ack never drops, so the counter expires 8 cycles after WAIT_LOW entry.
   task automatic test_timeout();
      wack = 1'b1; sdata = 32'h0000_5A5A; sreq = 1'b1;
      tick();
      checks++; if (svld !== 1'b1) begin errors++; $display("FAIL timeout_issue: got %b want 1", svld); end
      for (int i = 0; i < 8; i++) tick();
      checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", sdone); end
      tick();
      checks++; if ({sdone, serr, sres} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL timeout_done: got %b/%b/%h want 1/1/0", sdone, serr, sres); end
      sreq = 1'b0; wdata = 32'h0000_0077; wreq = 1'b1;
      tick();
      checks++; if ({serr, busy} !== 2'b00) begin errors++; $display("FAIL timeout_return_idle: got %b want 00", {serr, busy}); end
      tick();
      checks++; if ({wvld, wdo} !== {1'b1, 32'h0000_0077}) begin errors++; $display("FAIL timeout_next_grant: got %b/%h want 1/00000077", wvld, wdo); end
      tick();
      wack = 1'b0;
      tick();
      wack = 1'b1;
      tick();
      checks++; if ({wdone, werr} !== 2'b10) begin errors++; $display("FAIL timeout_next_done: got %b want 10", {wdone, werr}); end
      wreq = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      wdata = 32'h0000_0001; sdata = 32'h0000_0002;
      wreq = 1'b1; sreq = 1'b1; wack = 1'b1;
      tick();
      checks++; if ({svld, owner} !== 2'b11) begin errors++; $display("FAIL rstmid_rr_grant: got %b want 11", {svld, owner}); end
      tick();
      wack = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      checks++; if ({wvld, svld, wdone, sdone, werr, serr, busy, owner, phase, wdo, sdo} !== 74'd0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", {wvld, svld, wdone, sdone, werr, serr, busy, owner, phase, wdo, sdo}); end
      wack = 1'b1;
      tick();
      checks++; if ({sdone, wdone, busy} !== 3'b000) begin errors++; $display("FAIL rstmid_no_done: got %b want 000", {sdone, wdone, busy}); end
      rst_n = 1'b1;
      tick();
      checks++; if ({wvld, svld, owner} !== 3'b100) begin errors++; $display("FAIL rstmid_wish_wins: got %b want 100", {wvld, svld, owner}); end
      tick();
      wack = 1'b0;
      tick();
      wack = 1'b1;
      tick();
      checks++; if ({wdone, sdone} !== 2'b10) begin errors++; $display("FAIL rstmid_after_done: got %b want 10", {wdone, sdone}); end
      wreq = 1'b0; sreq = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_tie();
      test_weight();
      test_conv();
      test_not_ready();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
